// File: rtl/seq_multiplier_if.sv
// Operand/handshake/result bundle for seq_multiplier.
// signed_mode exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   data_in;
    logic               load_a;
    logic               load_b;
    logic               start;
`ifdef SEQ_MULT_SIGNED_EN
    logic               signed_mode;
`endif
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;

    modport master (
`ifdef SEQ_MULT_SIGNED_EN
        output signed_mode,
`endif
        output data_in, load_a, load_b, start,
        input  op_a, op_b, busy, done, result
    );

    modport slave (
`ifdef SEQ_MULT_SIGNED_EN
        input  signed_mode,
`endif
        input  data_in, load_a, load_b, start,
        output op_a, op_b, busy, done, result
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: operand capture, start/done handshake, held result.
// Optional two's-complement mode is built only when SEQ_MULT_SIGNED_EN is defined.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    seq_multiplier_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   op_a_reg;
    logic [WIDTH-1:0]   op_b_reg;
    logic [WIDTH-1:0]   mult_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_final;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_reg;
    logic a_neg;
    logic b_neg;

    // Magnitudes are taken before the unsigned iteration; -2^(WIDTH-1) maps to 2^(WIDTH-1).
    always_comb begin
        a_neg     = bus.signed_mode & op_a_reg[WIDTH-1];
        b_neg     = bus.signed_mode & op_b_reg[WIDTH-1];
        a_mag     = a_neg ? -op_a_reg : op_a_reg;
        b_mag     = b_neg ? -op_b_reg : op_b_reg;
        acc_final = neg_reg ? -acc_reg : acc_reg;
    end
`else
    always_comb begin
        a_mag     = op_a_reg;
        b_mag     = op_b_reg;
        acc_final = acc_reg;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            mult_reg   <= '0;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.load_a) op_a_reg <= bus.data_in;
                    if (bus.load_b) op_b_reg <= bus.data_in;
                    // Working copies come from the pre-edge operands, so a same-cycle load affects the next run.
                    if (bus.start) begin
                        mult_reg  <= b_mag;
                        mcand_reg <= {{WIDTH{1'b0}}, a_mag};
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
                        neg_reg   <= a_neg ^ b_neg;
`endif
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (mult_reg[0]) acc_reg <= acc_reg + mcand_reg;
                    mult_reg  <= mult_reg >> 1;
                    mcand_reg <= mcand_reg << 1;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) state_reg <= DONE;
                end
                DONE: begin
                    result_reg <= acc_final;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.op_a   = op_a_reg;
    assign bus.op_b   = op_b_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed table-driven bench for seq_multiplier (WIDTH=8), plus handshake corner sequences.
module tb_seq_multiplier;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(W)) bus ();
    seq_multiplier #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sm;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sm(input logic sm);
`ifdef SEQ_MULT_SIGNED_EN
        bus.signed_mode = sm;
`else
        if (sm) $display("note: signed vector skipped in unsigned build");
`endif
    endtask

    task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.data_in = a; bus.load_a = 1'b1; tick(); bus.load_a = 1'b0;
        bus.data_in = b; bus.load_b = 1'b1; tick(); bus.load_b = 1'b0;
    endtask

    // Call right after the start edge; returns cycles until done and busy-high samples seen.
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = bus.busy ? 1 : 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (bus.done) break;
            if (bus.busy) bc++;
        end
    endtask

    int cyc, bc, cnt;

    initial begin
        bus.data_in = '0; bus.load_a = 1'b0; bus.load_b = 1'b0; bus.start = 1'b0;
        set_sm(1'b0);

        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'h00, 8'hA5, 1'b0, 16'h0000});
        vecs.push_back('{8'h0C, 8'h0A, 1'b0, 16'h0078});
        vecs.push_back('{8'h01, 8'hFF, 1'b0, 16'h00FF});
        vecs.push_back('{8'h80, 8'h02, 1'b0, 16'h0100});
        vecs.push_back('{8'h0F, 8'h11, 1'b0, 16'h00FF});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
`ifdef SEQ_MULT_SIGNED_EN
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'hFF, 8'h01, 1'b1, 16'hFFFF});
        vecs.push_back('{8'hFD, 8'h04, 1'b1, 16'hFFF4});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
`endif

        #12;
        check("reset result", 32'(bus.result), 32'h0);
        check("reset busy",   32'(bus.busy),   32'h0);
        check("reset done",   32'(bus.done),   32'h0);
        check("reset op_a",   32'(bus.op_a),   32'h0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            load_ops(vecs[i].a, vecs[i].b);
            set_sm(vecs[i].sm);
            bus.start = 1'b1; tick(); bus.start = 1'b0;
            set_sm(1'b0);
            wait_done(cyc, bc);
            check($sformatf("vec%0d %h*%h sm=%0d result", i, vecs[i].a, vecs[i].b, vecs[i].sm),
                  32'(bus.result), 32'(vecs[i].exp));
            check($sformatf("vec%0d latency", i), 32'(cyc), 32'(W + 1));
            check($sformatf("vec%0d busy cycles", i), 32'(bc), 32'(W + 1));
            tick();
            check($sformatf("vec%0d done one-shot", i), 32'(bus.done), 32'h0);
        end

        // Loads without start leave the held result untouched.
        load_ops(8'h00, 8'hA5);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_done(cyc, bc);
        bus.data_in = 8'h03; bus.load_a = 1'b1; tick(); bus.load_a = 1'b0;
        tick(); tick();
        check("load-only result held", 32'(bus.result), 32'h0);
        check("load-only op_a", 32'(bus.op_a), 32'h03);

        // start/load_a during busy are ignored.
        load_ops(8'd12, 8'd10);
        bus.start = 1'b1; tick();
        bus.data_in = 8'h77; bus.load_a = 1'b1;
        repeat (4) tick();
        bus.start = 1'b0; bus.load_a = 1'b0;
        wait_done(cyc, bc);
        check("busy-ignore result", 32'(bus.result), 32'd120);
        check("busy-ignore op_a", 32'(bus.op_a), 32'd12);
        cnt = 0;
        repeat (14) begin tick(); if (bus.done || bus.busy) cnt++; end
        check("busy-ignore no queued op", 32'(cnt), 32'h0);

        // Same-cycle load and start uses the old operand.
        load_ops(8'd5, 8'd6);
        bus.data_in = 8'd9; bus.load_a = 1'b1; bus.start = 1'b1; tick();
        bus.load_a = 1'b0; bus.start = 1'b0;
        wait_done(cyc, bc);
        check("load+start result", 32'(bus.result), 32'd30);
        check("load+start op_a", 32'(bus.op_a), 32'd9);

        // Start held high: back-to-back with one idle cycle.
        load_ops(8'd3, 8'd4);
        bus.start = 1'b1; tick();
        wait_done(cyc, bc);
        check("b2b first result", 32'(bus.result), 32'd12);
        wait_done(cyc, bc);
        bus.start = 1'b0;
        check("b2b done interval", 32'(cyc), 32'(W + 2));
        check("b2b second result", 32'(bus.result), 32'd12);
        tick(); tick();

        // Asynchronous reset in the middle of a run.
        load_ops(8'hFF, 8'hFF);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (3) tick();
        check("pre-reset busy", 32'(bus.busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-run reset result", 32'(bus.result), 32'h0);
        check("mid-run reset busy",   32'(bus.busy),   32'h0);
        check("mid-run reset op_a",   32'(bus.op_a),   32'h0);
        check("mid-run reset op_b",   32'(bus.op_b),   32'h0);
        cnt = 0;
        repeat (3) begin tick(); if (bus.done) cnt++; end
        rst_n = 1'b1;
        repeat (12) begin tick(); if (bus.done || bus.busy) cnt++; end
        check("mid-run reset no done", 32'(cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
